// File: rtl/vec_intr_ctrl.sv
// vec_intr_ctrl: vectored priority interrupt controller.
//
// Collects N_SRC request lines, applies per-source masking and edge/level
// mode, and presents the highest-priority eligible request (index 0 highest)
// to the CPU as intr plus a vector number. Sources in service are tracked in
// INSVC, and only a strictly higher priority source may nest.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   irq        raw source requests, synchronous to clk
//   we         register write strobe
//   addr       register select: 0 MASK, 1 MODE, 2 PEND, 3 INSVC (write = EOI)
//   wdata      register write data
//   rdata      registered read data of reg[addr] (1-cycle latency)
//   intr       interrupt request to CPU
//   inta       one-cycle acknowledge pulse from CPU
//   vec        vector of the request being presented
//   dbg_state  current FSM state (0 IDLE, 1 REQ)
//
// Handshake: intr acts as "valid" and inta as "ready". Once intr rises, intr
// and vec hold unchanged until the cycle in which inta=1 is sampled. That cycle
// completes the transfer, and intr drops on the same edge. inta outside REQ
// is ignored.
module vec_intr_ctrl #(
  parameter int N_SRC = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_SRC-1:0] irq,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [N_SRC-1:0] wdata,
  output logic [N_SRC-1:0] rdata,
  output logic             intr,
  input  logic             inta,
  output logic [VEC_W-1:0] vec,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t           state;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pend_e;   // latched edge requests; meaningful only where mode=1
  logic [N_SRC-1:0] insvc;

  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] eoi;
  logic [N_SRC-1:0] ack_set;
  logic [N_SRC-1:0] eligible;
  logic             ack;
  logic             blocked;
  logic             any_elig;
  logic [VEC_W-1:0] pick;

  // Level bits follow the input register directly, so level and edge sources
  // share the same request-to-intr latency.
  assign pend    = (mode & pend_e) | (~mode & irq_q);
  assign rise    = irq & ~irq_q;
  assign w1c     = (we && addr == 2'd2) ? wdata : '0;
  assign eoi     = (we && addr == 2'd3) ? wdata : '0;
  assign ack     = (state == REQ) && inta;
  assign ack_set = ack ? ({{(N_SRC-1){1'b0}}, 1'b1} << vec) : '0;

  assign dbg_state = (state == REQ);

  // A source is eligible only if no source of equal or higher priority is in
  // service; the running OR of insvc implements "index < ceiling".
  always_comb begin
    blocked  = 1'b0;
    eligible = '0;
    for (int i = 0; i < N_SRC; i++) begin
      blocked     = blocked | insvc[i];
      eligible[i] = pend[i] & mask[i] & ~blocked;
    end
  end

  // Lowest set index wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    any_elig = |eligible;
    pick     = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) pick = VEC_W'(i);
    end
  end

  // Register file, input register and read port.
  always_ff @(posedge clk) begin
    if (clr) begin
      irq_q  <= '0;
      mask   <= '0;
      mode   <= '0;
      pend_e <= '0;
      insvc  <= '0;
      rdata  <= '0;
    end else begin
      irq_q <= irq;
      if (we && addr == 2'd0) mask <= wdata;
      if (we && addr == 2'd1) mode <= wdata;
      // A new rising edge outranks both W1C and acknowledge clears.
      pend_e <= mode & ((pend_e & ~w1c & ~ack_set) | rise);
      // Acknowledge outranks a simultaneous EOI of the same bit.
      insvc  <= (insvc & ~eoi) | ack_set;
      case (addr)
        2'd0:    rdata <= mask;
        2'd1:    rdata <= mode;
        2'd2:    rdata <= pend;
        default: rdata <= insvc;
      endcase
    end
  end

  // Request FSM; vec and intr are frozen for the whole REQ state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      intr  <= 1'b0;
      vec   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            vec   <= pick;
            intr  <= 1'b1;
            state <= REQ;
          end else begin
            intr <= 1'b0;
          end
        end
        default: begin
          if (inta) begin
            intr  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_intr_ctrl.sv
// tb_vec_intr_ctrl: directed self-checking bench for vec_intr_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_vec_intr_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] irq = 8'hFF;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       intr;
  logic       inta = 1'b0;
  logic [2:0] vec;
  logic       dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] rv;

  vec_intr_ctrl #(.N_SRC(8), .VEC_W(3)) dut (
    .clk(clk), .clr(clr), .irq(irq), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .intr(intr), .inta(inta), .vec(vec), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; wdata = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    tick();
    d = rdata;
  endtask

  task automatic ack_pulse();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; irq = 8'hFF;
    tick(); tick();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL reset_intr: got %b want 0", intr); end
    n_vec++; if (vec !== 3'd0) begin n_bad++; $display("FAIL reset_vec: got %0d want 0", vec); end
    n_vec++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b want 0", dbg_state); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 00", a, rv); end
    end
    clr = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL reset_release_intr: got %b want 0", intr); end
    rd(2'd0, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL reset_mask: got %h want 00", rv); end
    rd(2'd2, rv);  // level mode everywhere, so PEND mirrors irq
    n_vec++; if (rv !== 8'hFF) begin n_bad++; $display("FAIL reset_pend_level: got %h want ff", rv); end
    rd(2'd3, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL reset_insvc: got %h want 00", rv); end
    irq = 8'h00;
    tick(); tick();
  endtask

  task automatic test_single_edge();
    wr(2'd0, 8'h08);
    wr(2'd1, 8'h08);
    irq = 8'h08;
    tick();
    irq = 8'h00;
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL single_early_intr: got %b want 0", intr); end
    tick();
    n_vec++; if (intr !== 1'b1) begin n_bad++; $display("FAIL single_intr: got %b want 1", intr); end
    n_vec++; if (vec !== 3'd3) begin n_bad++; $display("FAIL single_vec: got %0d want 3", vec); end
    ack_pulse();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL single_ack_intr: got %b want 0", intr); end
    rd(2'd3, rv);
    n_vec++; if (rv !== 8'h08) begin n_bad++; $display("FAIL single_insvc: got %h want 08", rv); end
    rd(2'd2, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL single_pend: got %h want 00", rv); end
    wr(2'd3, 8'h08);
    rd(2'd3, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL single_eoi: got %h want 00", rv); end
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL single_post_intr: got %b want 0", intr); end
  endtask

  task automatic test_priority_nesting();
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'hFF);
    irq = 8'h60;
    tick();
    irq = 8'h00;
    tick();
    n_vec++; if (vec !== 3'd5 || intr !== 1'b1) begin n_bad++; $display("FAIL prio_vec5: got intr=%b vec=%0d want 1/5", intr, vec); end
    ack_pulse();
    tick();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL prio_block6: got %b want 0", intr); end
    irq = 8'h04;
    tick();
    irq = 8'h00;
    tick();
    n_vec++; if (vec !== 3'd2 || intr !== 1'b1) begin n_bad++; $display("FAIL prio_nest2: got intr=%b vec=%0d want 1/2", intr, vec); end
    rd(2'd3, rv);
    n_vec++; if (rv !== 8'h20) begin n_bad++; $display("FAIL prio_insvc5: got %h want 20", rv); end
    ack_pulse();
    irq = 8'h80;
    tick();
    irq = 8'h00;
    tick(); tick();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL prio_block7: got %b want 0", intr); end
    wr(2'd3, 8'h04);
    tick();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL prio_block_after_eoi2: got %b want 0", intr); end
    wr(2'd3, 8'h20);
    tick();
    n_vec++; if (vec !== 3'd6 || intr !== 1'b1) begin n_bad++; $display("FAIL prio_vec6: got intr=%b vec=%0d want 1/6", intr, vec); end
    ack_pulse();
    wr(2'd3, 8'h40);
    tick();
    n_vec++; if (vec !== 3'd7 || intr !== 1'b1) begin n_bad++; $display("FAIL prio_vec7: got intr=%b vec=%0d want 1/7", intr, vec); end
    ack_pulse();
    wr(2'd3, 8'h80);
  endtask

  task automatic test_frozen_vector();
    irq = 8'h10;
    tick();
    irq = 8'h00;
    tick();
    n_vec++; if (vec !== 3'd4 || intr !== 1'b1) begin n_bad++; $display("FAIL frozen_vec4: got intr=%b vec=%0d want 1/4", intr, vec); end
    irq = 8'h02;
    tick();
    irq = 8'h00;
    tick();
    n_vec++; if (vec !== 3'd4 || intr !== 1'b1) begin n_bad++; $display("FAIL frozen_hold: got intr=%b vec=%0d want 1/4", intr, vec); end
    ack_pulse();
    tick();
    n_vec++; if (vec !== 3'd1 || intr !== 1'b1) begin n_bad++; $display("FAIL frozen_next1: got intr=%b vec=%0d want 1/1", intr, vec); end
    ack_pulse();
    wr(2'd3, 8'h12);
    rd(2'd3, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL frozen_eoi: got %h want 00", rv); end
  endtask

  task automatic test_level_mode();
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h00);
    irq = 8'h01;
    tick(); tick();
    n_vec++; if (vec !== 3'd0 || intr !== 1'b1) begin n_bad++; $display("FAIL level_req: got intr=%b vec=%0d want 1/0", intr, vec); end
    ack_pulse();
    tick();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL level_insvc_block: got %b want 0", intr); end
    wr(2'd3, 8'h01);
    tick();
    n_vec++; if (vec !== 3'd0 || intr !== 1'b1) begin n_bad++; $display("FAIL level_rereq: got intr=%b vec=%0d want 1/0", intr, vec); end
    ack_pulse();
    irq = 8'h00;
    wr(2'd3, 8'h01);
    rd(2'd2, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL level_pend_drop: got %h want 00", rv); end
    tick();
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL level_no_rereq: got %b want 0", intr); end
  endtask

  task automatic test_collisions();
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h08);
    irq = 8'h08;
    tick();
    irq = 8'h00;
    tick();
    irq = 8'h08;
    wr(2'd2, 8'h08);   // new edge and W1C in the same cycle
    irq = 8'h00;
    rd(2'd2, rv);
    n_vec++; if (rv !== 8'h08) begin n_bad++; $display("FAIL coll_pend_set_wins: got %h want 08", rv); end
    wr(2'd2, 8'h08);
    rd(2'd2, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL coll_pend_w1c: got %h want 00", rv); end
    wr(2'd0, 8'h08);
    irq = 8'h08;
    tick();
    irq = 8'h00;
    tick();
    n_vec++; if (vec !== 3'd3 || intr !== 1'b1) begin n_bad++; $display("FAIL coll_req3: got intr=%b vec=%0d want 1/3", intr, vec); end
    inta = 1'b1;
    wr(2'd3, 8'h08);   // acknowledge and EOI of the same bit together
    inta = 1'b0;
    rd(2'd3, rv);
    n_vec++; if (rv !== 8'h08) begin n_bad++; $display("FAIL coll_insvc_set_wins: got %h want 08", rv); end
    wr(2'd0, 8'h0C);
    wr(2'd1, 8'h0C);
    irq = 8'h04;
    tick();
    irq = 8'h00;
    tick();
    n_vec++; if (vec !== 3'd2 || intr !== 1'b1) begin n_bad++; $display("FAIL coll_req2: got intr=%b vec=%0d want 1/2", intr, vec); end
    clr = 1'b1;
    tick();
    n_vec++; if (intr !== 1'b0 || vec !== 3'd0) begin n_bad++; $display("FAIL coll_clr_intr: got intr=%b vec=%0d want 0/0", intr, vec); end
    clr = 1'b0;
    rd(2'd3, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL coll_clr_insvc: got %h want 00", rv); end
    rd(2'd0, rv);
    n_vec++; if (rv !== 8'h00) begin n_bad++; $display("FAIL coll_clr_mask: got %h want 00", rv); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority_nesting();
    test_frozen_vector();
    test_level_mode();
    test_collisions();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
